// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: funct3 encodings,
// FSM state enum and the captured-request record.
package dmem_responder_pkg;

  // Widest byte address the captured request can hold; DM_ADDRESS must not exceed it.
  localparam int REQ_ADDR_W = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_rsp_state_t;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [2:0]            funct3;
  } dmem_req_t;

  function automatic logic f3_is_store(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  function automatic logic f3_is_load(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave).
interface dmem_responder_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: load extract/extend, store byte
// enables and lane replication, and the access-error flag (DMEM_MISALIGN_CHECK_EN).
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword[7:0];
    case (addr_lo)
      2'd0: byte_sel = rword[7:0];
      2'd1: byte_sel = rword[15:8];
      2'd2: byte_sel = rword[23:16];
      2'd3: byte_sel = rword[31:24];
      default: byte_sel = rword[7:0];
    endcase
    // addr_lo[0] is deliberately ignored for halfwords; the error check catches it when enabled
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:  load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:  load_data = rword;
      F3_BU: load_data = {24'd0, byte_sel};
      F3_HU: load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = '0;
    if (we) begin
      case (funct3)
        F3_B: begin
          byte_en    = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        F3_H: begin
          byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lane = {2{wdata[15:0]}};
        end
        F3_W: begin
          byte_en    = 4'b1111;
          wdata_lane = wdata;
        end
        default: begin
          byte_en    = 4'b0000;
          wdata_lane = '0;
        end
      endcase
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    err = 1'b0;
    if (we ? !f3_is_store(funct3) : !f3_is_load(funct3)) begin
      err = 1'b1;
    end else begin
      case (funct3)
        F3_H, F3_HU: err = addr_lo[0];
        F3_W:        err = (addr_lo != 2'b00);
        default:     err = 1'b0;
      endcase
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time with a fixed access latency.
// Optional DMEM_MISALIGN_CHECK_EN turns misaligned/unsupported accesses into errors.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | req_ready high, waiting for a request
// BUSY  | latency down-counter running; access happens when it hits 0
// RESP  | rsp_valid high for one cycle, no new request accepted
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2
) (
  input logic            clk,
  input logic            reset,
  dmem_responder_if.slave bus
);

  localparam int         IDX_W    = DM_ADDRESS - 2;
  localparam int         WORDS    = 1 << IDX_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_rsp_state_t   state, state_d;
  logic [3:0]        cnt, cnt_d;
  dmem_req_t         req_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic [31:0]       mem [WORDS];
  logic [IDX_W-1:0]  idx;
  logic [1:0]        addr_lo;
  logic [31:0]       rword;
  logic [31:0]       load_data;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lane;
  logic              lane_err;
  logic              accept;
  logic              access;
  logic              unused_addr;

  assign idx         = req_q.addr[DM_ADDRESS-1:2];
  assign addr_lo     = req_q.addr[1:0];
  assign rword       = mem[idx];
  assign unused_addr = ^req_q.addr;

  assign accept = (state == ST_IDLE) && bus.req_valid;
  assign access = (state == ST_BUSY) && (cnt == 4'd0);

  dmem_lane_align u_lane (
    .we         (req_q.we),
    .funct3     (req_q.funct3),
    .addr_lo    (addr_lo),
    .rword      (rword),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .err        (lane_err)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      ST_BUSY: begin
        if (cnt == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        req_q.we     <= bus.req_we;
        req_q.addr   <= REQ_ADDR_W'(bus.req_addr);
        req_q.wdata  <= bus.req_wdata;
        req_q.funct3 <= bus.req_funct3;
      end
      // Response data is registered at the access edge and held until the next access
      if (access) begin
        rsp_err_q   <= lane_err;
        rsp_rdata_q <= (req_q.we || lane_err) ? '0 : load_data;
      end
    end
  end

  // Storage has no reset; a discarded request never reaches BUSY with cnt==0
  always_ff @(posedge clk) begin
    if (access && req_q.we && !lane_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench for dmem_responder with a response scoreboard, plus
// hand-written handshake and reset-abort sequences.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int LAT = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vec_t        vecs[$];
  exp_t        sb[$];
  int          applied     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [31:0] last_rdata  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic err, input int acc);
    exp_t e;
    e.rdata = rdata; e.err = err; e.acc = acc;
    sb.push_back(e);
  endtask

  // Scoreboard: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        check("rsp_latency", 32'(cyc - e.acc), 32'(LAT));
        last_rdata = e.rdata;
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic drive_req(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
  endtask

  task automatic drive_garbage();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_addr   = 9'($urandom);
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    check({name, "_ready"}, 32'(bus.req_ready), 32'd1);
    drive_req(v.we, v.addr, v.wdata, v.f3);
    push_exp(v.exp_rdata, v.exp_err, cyc + 1);
    @(negedge clk);
    drive_garbage();
    wait_drain(name);
    @(negedge clk);
    check({name, "_single_pulse"}, 32'(bus.rsp_valid), 32'd0);
    check({name, "_rdata_hold"}, bus.rsp_rdata, last_rdata);
    check({name, "_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  logic [31:0] w10;

  initial begin
    int a0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_funct3 = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rdata", bus.rsp_rdata, 32'd0);
    check("reset_err", 32'(bus.rsp_err), 32'd0);
    reset = 1'b0;

    vecs.push_back(mk(1, 9'h010, 32'h12345678, F3_W,  32'h0, 0));
    vecs.push_back(mk(0, 9'h010, 32'h0,        F3_W,  32'h12345678, 0));
    vecs.push_back(mk(1, 9'h013, 32'h000000AB, F3_B,  32'h0, 0));
    vecs.push_back(mk(0, 9'h010, 32'h0,        F3_W,  32'hAB345678, 0));
    vecs.push_back(mk(0, 9'h013, 32'h0,        F3_B,  32'hFFFFFFAB, 0));
    vecs.push_back(mk(0, 9'h013, 32'h0,        F3_BU, 32'h000000AB, 0));
    vecs.push_back(mk(1, 9'h014, 32'hDEADBEEF, F3_W,  32'h0, 0));
    vecs.push_back(mk(1, 9'h016, 32'h00008001, F3_H,  32'h0, 0));
    vecs.push_back(mk(0, 9'h016, 32'h0,        F3_H,  32'hFFFF8001, 0));
    vecs.push_back(mk(0, 9'h016, 32'h0,        F3_HU, 32'h00008001, 0));
    vecs.push_back(mk(0, 9'h014, 32'h0,        F3_W,  32'h8001BEEF, 0));
    vecs.push_back(mk(0, 9'h010, 32'h0,        F3_B,  32'h00000078, 0));
    vecs.push_back(mk(0, 9'h012, 32'h0,        F3_H,  32'hFFFFAB34, 0));
    vecs.push_back(mk(0, 9'h010, 32'h0,        F3_HU, 32'h00005678, 0));
    vecs.push_back(mk(0, 9'h010, 32'h0,        3'b011, 32'h0, MIS));
    vecs.push_back(mk(0, 9'h010, 32'h0,        3'b110, 32'h0, MIS));
    vecs.push_back(mk(1, 9'h010, 32'h55AA55AA, 3'b100, 32'h0, MIS));
    vecs.push_back(mk(0, 9'h010, 32'h0,        F3_W,  32'hAB345678, 0));
    vecs.push_back(mk(0, 9'h017, 32'h0,        F3_H,  MIS ? 32'h0 : 32'hFFFF8001, MIS));
    vecs.push_back(mk(0, 9'h011, 32'h0,        F3_W,  MIS ? 32'h0 : 32'hAB345678, MIS));
    vecs.push_back(mk(1, 9'h011, 32'hFFFFFFFF, F3_W,  32'h0, MIS));
    vecs.push_back(mk(0, 9'h010, 32'h0,        F3_W,  MIS ? 32'hAB345678 : 32'hFFFFFFFF, 0));
    vecs.push_back(mk(1, 9'h020, 32'hCAFEF00D, F3_W,  32'h0, 0));
    vecs.push_back(mk(0, 9'h020, 32'h0,        F3_W,  32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 9'h1FC, 32'h89ABCDEF, F3_W,  32'h0, 0));
    vecs.push_back(mk(0, 9'h1FF, 32'h0,        F3_BU, 32'h00000089, 0));
    vecs.push_back(mk(0, 9'h1FC, 32'h0,        F3_B,  32'hFFFFFFEF, 0));
    vecs.push_back(mk(0, 9'h1FE, 32'h0,        F3_HU, 32'h000089AB, 0));
    vecs.push_back(mk(1, 9'h1FD, 32'h123456C3, F3_B,  32'h0, 0));
    vecs.push_back(mk(0, 9'h1FC, 32'h0,        F3_W,  32'h89ABC3EF, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // req_valid held high: second accept exactly LAT+2 edges after the first
    w10 = MIS ? 32'hAB345678 : 32'hFFFFFFFF;
    @(negedge clk);
    check("hs_ready_start", 32'(bus.req_ready), 32'd1);
    drive_req(1'b0, 9'h010, 32'h0, F3_W);
    a0 = cyc + 1;
    push_exp(w10, 1'b0, a0);
    push_exp(w10, 1'b0, a0 + LAT + 2);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check($sformatf("hs_ready_low%0d", k), 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    check("hs_ready_high", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    check("hs_second_accept", 32'(bus.req_ready), 32'd0);
    drive_garbage();
    wait_drain("hs");

    // Reset in the first BUSY cycle of a store discards it with no response
    @(negedge clk);
    drive_req(1'b1, 9'h020, 32'h00000055, F3_W);
    @(negedge clk);
    drive_garbage();
    check("abort_busy", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_rdata", bus.rsp_rdata, 32'd0);
    check("abort_err", 32'(bus.rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_rdata = '0;
    repeat (LAT + 3) @(negedge clk);
    run_vec(mk(0, 9'h020, 32'h0, F3_W, 32'hCAFEF00D, 0), "abort_reload");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, applied=%0d", applied);
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

- Data-memory responder serving load/store requests from the pipeline's MEM stage.
- Accepts one request at a time through a valid/ready handshake and applies a fixed, parameterised access latency.
- Performs byte/halfword/word accesses selected by funct3, with sign or zero extension on loads.
- Returns exactly one single-cycle response per accepted request; the MEM stage stalls while `req_ready` is low.

## Interface
Parameters:
- DM_ADDRESS, 9 — byte-address width; storage is 2^(DM_ADDRESS-2) words.
- DATA_W, 32 — data width; fixed at 32 (lane logic assumes 4 bytes).
- LATENCY, 2 — BUSY cycles between accept and response; legal range 1..15.

Ports:
- clk  input  1  — clock; everything is sampled on the rising edge.
- reset  input  1  — asynchronous, active-high reset.
- req_valid  input  1  — request present.
- req_ready  output  1  — responder idle; the request is accepted when req_valid && req_ready at the rising edge.
- req_we  input  1  — 1 = store, 0 = load.
- req_addr  input  DM_ADDRESS  — byte address.
- req_wdata  input  DATA_W  — store data, right-aligned.
- req_funct3  input  3  — access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rsp_valid  output  1  — response strobe, high for exactly one cycle.
- rsp_rdata  output  DATA_W  — extended load data; 0 for stores and errors.
- rsp_err  output  1  — access error; valid only with rsp_valid.

## Operation
States IDLE, BUSY and RESP; the state register is asynchronously reset to IDLE.

- **IDLE:** req_ready=1.
  - On accept: capture we/addr/wdata/funct3 and load the counter with LATENCY-1, then go to BUSY.
- **BUSY:** req_ready=0.
  - Each cycle, decrement the counter.
  - When the counter is 0, perform the access at the clock edge and go to RESP.
- **RESP:** rsp_valid=1 for one cycle, then go to IDLE.
  - There is no response back-pressure.
  - A new request cannot be accepted in the RESP cycle.

Loads:
- The word is indexed by addr[DM_ADDRESS-1:2] and the byte lane by addr[1:0].
- B/H results are sign-extended; BU/HU results are zero-extended.

Stores:
- Byte-enable merge into the addressed word:
  - SB writes lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
- Store funct3 values other than 000/001/010 write nothing.

Load funct3 011/110/111: rsp_rdata=0.

Inputs while req_ready=0 are ignored; req_* need only be stable in the accept cycle.

Storage is not cleared by reset.

Reset mid-operation:
- The pending request is discarded immediately.
- A pending store is not written.
- No response is produced for the discarded request.

## Timing
- Acceptance edge = cycle 0.
- BUSY occupies cycles 1..LATENCY.
- rsp_valid/rsp_rdata/rsp_err are valid in cycle LATENCY+1.
- req_ready rises in cycle LATENCY+2.
- Throughput: one access per LATENCY+2 cycles.
- rsp_rdata and rsp_err are registered; they hold their value until the next response.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.

## Configuration
DMEM_MISALIGN_CHECK_EN

Defined:
- An H/HU/SH access with addr[0]=1 is an error.
- A W/SW access with addr[1:0]≠0 is an error.
- Unsupported funct3 is an error.
- On error: the access is suppressed (no write), rsp_rdata=0 and rsp_err=1 in RESP.

Undefined:
- Low address bits are truncated: halfwords use addr[1], words ignore addr[1:0].
- Unsupported funct3 behaves as described in Operation.
- rsp_err is tied to 0.

## Structure
Shared package entries:
- funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
- State enum `dmem_rsp_state_t`.
- A request struct holding we/addr/wdata/funct3.

Sub-module `dmem_lane_align` (combinational):
- Load path: lane extract plus extension.
- Store path: 4-bit byte-enable and shifted write data.
- Misalign/illegal flag.

Top level holds the FSM, the counter, the captured request and the word array.

## Test plan
- **Word round trip:** after reset, SW 0x12345678 @0x10, then LW @0x10 → rsp_rdata=0x12345678, rsp_err=0, rsp_valid exactly in cycle LATENCY+1 after accept.
- **Byte lanes:** SB 0xAB @0x13 over that word.
  - LW @0x10 → 0xAB345678.
  - LB @0x13 → 0xFFFFFFAB.
  - LBU @0x13 → 0x000000AB.
- **Halfword:** SH 0x8001 @0x16.
  - LH @0x16 → 0xFFFF8001.
  - LHU @0x16 → 0x00008001.
  - LW @0x14 → 0x8001xxxx, with the upper half written and the lower half unchanged.
- **Misalignment:** LW @0x11.
  - Macro defined → rsp_err=1, rdata=0; SW 0xFFFFFFFF @0x11 leaves word 0x10 unchanged.
  - Macro undefined → LW @0x11 returns word 0x10.
- **Handshake:** req_valid held high continuously → req_ready=0 during BUSY/RESP; the second request is accepted only in cycle LATENCY+2; back-to-back responses are exactly LATENCY+2 cycles apart.
- **Reset abort:** reset asserted in the first BUSY cycle of SW 0x55 @0x20 → outputs return to reset values asynchronously, no rsp_valid pulse; LW @0x20 afterwards returns the prior contents.
